ps2_keyboard: RTL and testbench

- Memory-mapped PS/2 keyboard receiver on the shared 8-bit CPU data bus, alongside diodes, GPU and RAM.
- Deserialises PS/2 device frames and buffers scan codes in a small FIFO.
- The CPU reads scan codes and status through two byte registers.
- Board-level chip select is decoded from address_bus[15:12] == 4'b1010; address_bus[0] drives the address port.

---
 rtl/ps2_keyboard_pkg.sv | 37 +++
 rtl/sync_fifo.sv | 86 ++++++++
 rtl/ps2_keyboard.sv | 236 +++++++++++++++++++++++
 tb/tb_ps2_keyboard.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/ps2_keyboard_pkg.sv
// ---------------------------------------------------------------------------
// ps2_keyboard_pkg
// Shared definitions for the PS/2 keyboard receiver:
//   - receive FSM state encoding
//   - CPU register addresses and STATUS bit positions
//   - board-level chip-select nibble (address_bus[15:12])
//   - odd-parity helper
// ---------------------------------------------------------------------------
package ps2_keyboard_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } ps2_state_e;

    // Register select values seen on the 1-bit address port
    localparam logic REG_DATA   = 1'b0;
    localparam logic REG_STATUS = 1'b1;

    // STATUS register bit positions
    localparam int STAT_NOT_EMPTY = 0;
    localparam int STAT_FULL      = 1;
    localparam int STAT_OVF       = 2;
    localparam int STAT_PERR      = 3;
    localparam int STAT_FERR      = 4;

    // Decoded by board glue: cs = (address_bus[15:12] == BOARD_CS_NIBBLE)
    localparam logic [3:0] BOARD_CS_NIBBLE = 4'b1010;

    // True when the eight data bits plus the parity bit hold an odd number of ones
    function automatic logic odd_parity_ok(input logic [7:0] data, input logic parity);
        return ^{data, parity};
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// ---------------------------------------------------------------------------
// sync_fifo
// Small single-clock circular FIFO with a combinational head output.
// Ports:
//   clk   - clock
//   reset - asynchronous active-low reset (pointers and count cleared)
//   push  - write din this cycle (accepted when not full, or when a pop
//           happens in the same cycle)
//   pop   - remove head this cycle (ignored when empty)
//   din   - write data
//   dout  - current head entry (undefined content when empty)
//   full  - count == DEPTH
//   empty - count == 0
//   count - number of stored entries
// ---------------------------------------------------------------------------
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q,  count_d;
    logic             do_push, do_pop;

    assign full  = (count_q == (AW+1)'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign dout  = mem_q[rd_ptr_q];

    // A pop in the same cycle frees a slot, so a push into a full FIFO is
    // still accepted in that case.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset; stale contents are unreachable once the
    // pointers and count are cleared.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

endmodule

// File: rtl/ps2_keyboard.sv
// ---------------------------------------------------------------------------
// ps2_keyboard
// Memory-mapped PS/2 keyboard receiver. Deserialises device frames
// (start 0, 8 data bits LSB first, odd parity, stop 1), buffers scan codes
// in a FIFO and exposes them to the CPU through two byte registers.
// Ports:
//   clk      - system clock
//   reset    - asynchronous active-low reset
//   data_bus - shared 8-bit CPU bus; driven only while cs & read
//   address  - 0 = DATA (FIFO head, pops when the read ends), 1 = STATUS
//   cs       - chip select
//   read     - read strobe (level)
//   write    - write strobe (level); STATUS writes clear sticky flags
//   ps2_clk  - PS/2 clock from device (asynchronous)
//   ps2_data - PS/2 data from device (asynchronous)
//   irq      - high while the FIFO holds at least one scan code
// STATUS = {3'b0, ferr, perr, ovf, full, not_empty}
// ---------------------------------------------------------------------------
module ps2_keyboard
    import ps2_keyboard_pkg::*;
#(
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 16384
) (
    input  logic       clk,
    input  logic       reset,
    inout  wire  [7:0] data_bus,
    input  logic       address,
    input  logic       cs,
    input  logic       read,
    input  logic       write,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       irq
);

    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TIMEOUT_MAX = TW'(TIMEOUT_CYCLES - 1);

    // ---------------- input synchronisers (preset to bus idle level) -------
    logic ps2_clk_meta_q, ps2_clk_sync_q, ps2_clk_prev_q;
    logic ps2_data_meta_q, ps2_data_sync_q;
    logic fall;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ps2_clk_meta_q  <= 1'b1;
            ps2_clk_sync_q  <= 1'b1;
            ps2_clk_prev_q  <= 1'b1;
            ps2_data_meta_q <= 1'b1;
            ps2_data_sync_q <= 1'b1;
        end else begin
            ps2_clk_meta_q  <= ps2_clk;
            ps2_clk_sync_q  <= ps2_clk_meta_q;
            ps2_clk_prev_q  <= ps2_clk_sync_q;
            ps2_data_meta_q <= ps2_data;
            ps2_data_sync_q <= ps2_data_meta_q;
        end
    end

    assign fall = ps2_clk_prev_q & ~ps2_clk_sync_q;

    // ---------------- receive FSM -----------------------------------------
    ps2_state_e    state_q, state_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic          parity_q, parity_d;
    logic [TW-1:0] timeout_q, timeout_d;
    logic          push, perr_set, ferr_set;

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        parity_d  = parity_q;
        timeout_d = '0;
        push      = 1'b0;
        perr_set  = 1'b0;
        ferr_set  = 1'b0;

        if (state_q != ST_IDLE) begin
            timeout_d = fall ? '0 : timeout_q + TW'(1);
        end

        case (state_q)
            ST_IDLE: begin
                if (fall && !ps2_data_sync_q) begin
                    state_d   = ST_DATA;
                    bit_cnt_d = '0;
                end
            end
            ST_DATA: begin
                if (fall) begin
                    shift_d[bit_cnt_q] = ps2_data_sync_q;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = ST_PARITY;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end
            end
            ST_PARITY: begin
                if (fall) begin
                    parity_d = ps2_data_sync_q;
                    state_d  = ST_STOP;
                end
            end
            ST_STOP: begin
                if (fall) begin
                    state_d = ST_IDLE;
                    if (!ps2_data_sync_q) begin
                        ferr_set = 1'b1;
                    end else if (odd_parity_ok(shift_q, parity_q)) begin
                        push = 1'b1;
                    end else begin
                        perr_set = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Device went quiet mid-frame: abandon silently
        if (state_q != ST_IDLE && !fall && timeout_q == TIMEOUT_MAX) begin
            state_d = ST_IDLE;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            parity_q  <= 1'b0;
            timeout_q <= '0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            parity_q  <= parity_d;
            timeout_q <= timeout_d;
        end
    end

    // ---------------- FIFO and pop on end of DATA read --------------------
    logic                        rd_access;
    logic                        rd_q, rd_d;
    logic                        pop;
    logic [7:0]                  fifo_dout;
    logic                        fifo_full, fifo_empty;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;

    assign rd_access = cs & read & (address == REG_DATA);
    assign rd_d      = rd_access;
    // Pop when the DATA read ends so the head stays stable while it is read
    assign pop       = rd_q & ~rd_access;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_q <= 1'b0;
        end else begin
            rd_q <= rd_d;
        end
    end

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   (shift_q),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // ---------------- sticky error flags ----------------------------------
    logic ovf_q, ovf_d, perr_q, perr_d, ferr_q, ferr_d;
    logic status_wr, ovf_set;
    logic unused_bus_bits;

    assign status_wr = cs & write & (address == REG_STATUS);
    // Full FIFO is never empty, so any pop here frees the slot for the push
    assign ovf_set   = push & fifo_full & ~pop;
    assign unused_bus_bits = ^{data_bus[7:5], data_bus[1:0]};

    // Set wins over a same-cycle clear
    always_comb begin
        ovf_d  = (ovf_q  & ~(status_wr & data_bus[STAT_OVF]))  | ovf_set;
        perr_d = (perr_q & ~(status_wr & data_bus[STAT_PERR])) | perr_set;
        ferr_d = (ferr_q & ~(status_wr & data_bus[STAT_FERR])) | ferr_set;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ovf_q  <= 1'b0;
            perr_q <= 1'b0;
            ferr_q <= 1'b0;
        end else begin
            ovf_q  <= ovf_d;
            perr_q <= perr_d;
            ferr_q <= ferr_d;
        end
    end

    // ---------------- CPU read path ---------------------------------------
    logic [7:0] status;
    logic [7:0] rd_data;
    logic       not_empty;

    assign not_empty = (fifo_count != '0);
    assign irq       = not_empty;

    always_comb begin
        status                 = '0;
        status[STAT_NOT_EMPTY] = not_empty;
        status[STAT_FULL]      = fifo_full;
        status[STAT_OVF]       = ovf_q;
        status[STAT_PERR]      = perr_q;
        status[STAT_FERR]      = ferr_q;
    end

    always_comb begin
        rd_data = status;
        if (address == REG_DATA) begin
            rd_data = fifo_empty ? 8'h00 : fifo_dout;
        end
    end

    assign data_bus = (cs & read) ? rd_data : 8'hzz;

endmodule

// File: tb/tb_ps2_keyboard.sv
`timescale 1ns/1ps
// Directed bench for ps2_keyboard: 1 MHz system clock, 60 us PS/2 bit period.
module tb_ps2_keyboard;

    logic clk = 1'b0;
    logic reset;
    logic address, cs, read, write;
    logic ps2_clk, ps2_data;
    logic irq;
    logic       drv_en;
    logic [7:0] drv_val;
    wire  [7:0] data_bus;

    int vectors     = 0;
    int miscompares = 0;
    logic [7:0] rv;

    // Undriven bus floats to 8'hFF so high-Z is observable
    for (genvar gi = 0; gi < 8; gi++) begin : g_pu
        pullup (data_bus[gi]);
    end
    assign data_bus = drv_en ? drv_val : 8'hzz;

    always #500 clk = ~clk;

    ps2_keyboard #(
        .FIFO_DEPTH     (4),
        .TIMEOUT_CYCLES (16384)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .data_bus (data_bus),
        .address  (address),
        .cs       (cs),
        .read     (read),
        .write    (write),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .irq      (irq)
    );

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
        end
        $display("check %-14s observed %02h expected %02h", tag, obs, exp);
    endtask

    task automatic read_reg(input logic addr, output logic [7:0] val);
        cs = 1'b1; read = 1'b1; address = addr;
        tick(1);
        val = data_bus;
        cs = 1'b0; read = 1'b0;
        tick(1);
    endtask

    task automatic write_reg(input logic addr, input logic [7:0] val);
        drv_en = 1'b1; drv_val = val;
        cs = 1'b1; write = 1'b1; address = addr;
        tick(1);
        cs = 1'b0; write = 1'b0; drv_en = 1'b0;
        tick(1);
    endtask

    task automatic ps2_bit(input logic b);
        ps2_data = b;
        tick(15);
        ps2_clk = 1'b0;
        tick(30);
        ps2_clk = 1'b1;
        tick(15);
    endtask

    // Start bit, eight data bits LSB first, parity bit (no stop)
    task automatic send_head(input logic [7:0] b, input logic par);
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(b[i]);
        ps2_bit(par);
    endtask

    task automatic send_frame(input logic [7:0] b);
        send_head(b, ~^b);
        ps2_bit(1'b1);
    endtask

    initial begin
        #100ms;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b0; cs = 1'b0; read = 1'b0; write = 1'b0; address = 1'b0;
        ps2_clk = 1'b1; ps2_data = 1'b1; drv_en = 1'b0; drv_val = 8'h00;
        tick(3);
        check("rst_irq", {7'b0, irq}, 8'h00);
        check("rst_bus_z", data_bus, 8'hFF);
        reset = 1'b1;
        tick(2);
        read_reg(1'b1, rv); check("rst_status", rv, 8'h00);

        // Valid 8'h1C, with exact push latency around the stop-bit fall
        send_head(8'h1C, 1'b0);
        ps2_data = 1'b1;
        tick(15);
        ps2_clk = 1'b0;
        tick(2);
        check("a_irq_fall", {7'b0, irq}, 8'h00);
        tick(1);
        check("a_irq_next", {7'b0, irq}, 8'h01);
        cs = 1'b1; read = 1'b1; address = 1'b1; #1;
        check("a_status", data_bus, 8'h01);
        cs = 1'b0; read = 1'b0;
        tick(27);
        ps2_clk = 1'b1;
        tick(15);
        read_reg(1'b0, rv); check("a_data", rv, 8'h1C);
        check("a_irq_after", {7'b0, irq}, 8'h00);
        read_reg(1'b1, rv); check("a_status_end", rv, 8'h00);

        // Parity error
        send_head(8'h1C, 1'b1);
        ps2_bit(1'b1);
        check("b_irq", {7'b0, irq}, 8'h00);
        read_reg(1'b1, rv); check("b_status", rv, 8'h08);
        write_reg(1'b1, 8'h08);
        read_reg(1'b1, rv); check("b_clear", rv, 8'h00);

        // Overflow
        for (int i = 1; i <= 5; i++) send_frame(8'(i));
        read_reg(1'b1, rv); check("c_status", rv, 8'h07);
        for (int i = 1; i <= 4; i++) begin
            read_reg(1'b0, rv); check("c_data", rv, 8'(i));
        end
        read_reg(1'b1, rv); check("c_status_end", rv, 8'h04);
        read_reg(1'b0, rv); check("c_empty_data", rv, 8'h00);
        read_reg(1'b1, rv); check("c_status_pop0", rv, 8'h04);
        write_reg(1'b0, 8'h04);
        read_reg(1'b1, rv); check("c_data_wr", rv, 8'h04);
        write_reg(1'b1, 8'h04);
        read_reg(1'b1, rv); check("c_clear", rv, 8'h00);

        // Pop and push in the same cycle while full
        for (int i = 1; i <= 4; i++) send_frame(8'(i));
        read_reg(1'b1, rv); check("d_full", rv, 8'h03);
        cs = 1'b1; read = 1'b1; address = 1'b0;
        send_head(8'h55, 1'b1);
        check("d_head_held", data_bus, 8'h01);
        ps2_data = 1'b1;
        tick(15);
        ps2_clk = 1'b0;
        tick(2);
        cs = 1'b0; read = 1'b0;
        tick(1);
        read_reg(1'b1, rv); check("d_no_ovf", rv, 8'h03);
        tick(25);
        ps2_clk = 1'b1;
        tick(15);
        read_reg(1'b0, rv); check("d_data0", rv, 8'h02);
        read_reg(1'b0, rv); check("d_data1", rv, 8'h03);
        read_reg(1'b0, rv); check("d_data2", rv, 8'h04);
        read_reg(1'b0, rv); check("d_data3", rv, 8'h55);
        read_reg(1'b1, rv); check("d_status", rv, 8'h00);

        // Timeout mid-frame
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        ps2_data = 1'b1;
        tick(16384);
        read_reg(1'b1, rv); check("e_status", rv, 8'h00);
        check("e_irq", {7'b0, irq}, 8'h00);
        send_frame(8'hF0);
        read_reg(1'b1, rv); check("e_status2", rv, 8'h01);
        read_reg(1'b0, rv); check("e_data", rv, 8'hF0);

        // Reset mid-frame with two bytes buffered
        send_frame(8'hAA);
        send_frame(8'hBB);
        read_reg(1'b1, rv); check("f_status_pre", rv, 8'h01);
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        #200;
        reset = 1'b0;
        #1;
        check("f_irq", {7'b0, irq}, 8'h00);
        cs = 1'b1; read = 1'b1; address = 1'b1; #1;
        check("f_status_rst", data_bus, 8'h00);
        address = 1'b0; #1;
        check("f_data_rst", data_bus, 8'h00);
        cs = 1'b0; #1;
        check("f_bus_z_cs", data_bus, 8'hFF);
        cs = 1'b1; read = 1'b0; #1;
        check("f_bus_z_rd", data_bus, 8'hFF);
        cs = 1'b0;
        tick(2);
        reset = 1'b1;
        tick(5);
        read_reg(1'b1, rv); check("f_status_post", rv, 8'h00);
        check("f_irq_post", {7'b0, irq}, 8'h00);
        send_frame(8'h3C);
        read_reg(1'b0, rv); check("f_recover", rv, 8'h3C);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
